apb_protocol_checker: RTL and testbench

- Synthesizable, multi-channel APB protocol checker that replaces simulation-only assertions. It can be kept in FPGA/emulation builds.
- Passively observes NUM_CH independent APB channels and runs a per-channel SETUP/ACCESS state tracker with a wait-state timeout.
- Latches sticky per-channel error flags, raises one interrupt, and counts completed transfers.
- Sits beside the ICB-to-APB bridge outputs; drives no APB signal.

---
 rtl/apb_chk_pkg.sv | 29 ++
 rtl/apb_chk_ch.sv | 147 ++++++++++++++
 rtl/apb_protocol_checker.sv | 68 ++++++
 tb/tb_apb_protocol_checker.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_chk_pkg.sv
// rtl/apb_chk_pkg.sv - shared state type and error-bit indices for the APB protocol checker
//
// Error bits, one set per channel:
//   ERR_ORDER       penable seen where no SETUP precedes it, or penable dropped mid-ACCESS
//   ERR_NO_ACCESS   SETUP cycle not followed by an ACCESS cycle
//   ERR_UNSTABLE    paddr/pwrite (and pwdata on writes) moved during ACCESS
//   ERR_TIMEOUT     too many consecutive wait states
//   ERR_PSEL_DROP   psel released before the transfer completed
//   ERR_PREADY_HOLD pready still high in the idle cycle right after a completion
package apb_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_chk_state_e;

    localparam int ERR_ORDER       = 0;
    localparam int ERR_NO_ACCESS   = 1;
    localparam int ERR_UNSTABLE    = 2;
    localparam int ERR_TIMEOUT     = 3;
    localparam int ERR_PSEL_DROP   = 4;
    localparam int ERR_PREADY_HOLD = 5;
    localparam int ERR_N           = 6;

    // Wait counter width; covers the full TIMEOUT range of 1 .. 2^16-1.
    localparam int WAIT_W          = 16;

endpackage

// File: rtl/apb_chk_ch.sv
// rtl/apb_chk_ch.sv - single-channel APB SETUP/ACCESS tracker with sticky error flags
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   psel, penable,
//   pwrite, paddr,
//   pwdata, pready  observed APB channel (never driven)
//   err_clr         clears this channel's sticky flags (a same-cycle set wins)
//   err_flags       sticky error bits, indexed by the ERR_* constants
//   xfer_cnt        completed transfers, wraps modulo 2^CNT_W
module apb_chk_ch
    import apb_chk_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic              err_clr,
    output logic [ERR_N-1:0]  err_flags,
    output logic [CNT_W-1:0]  xfer_cnt
);

    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    apb_chk_state_e    state;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              cap_write;
    logic [WAIT_W-1:0] wait_cnt;
    logic              done;

    logic              in_access;
    logic [WAIT_W-1:0] wait_base;
    logic [WAIT_W-1:0] wait_inc;
    logic              mismatch;
    logic [ERR_N-1:0]  set_bits;

    // The first psel&penable cycle after SETUP is already an ACCESS cycle on
    // the bus: its pready can complete the transfer and its low pready counts
    // as the first wait state. wait_base restarts the count for that cycle,
    // so the counter register never needs an explicit clear on entry.
    always_comb begin
        in_access = (state == ACCESS) || ((state == SETUP) && psel && penable);
        wait_base = (state == ACCESS) ? wait_cnt : '0;
        wait_inc  = (wait_base == WAIT_MAX) ? wait_base : wait_base + 1'b1;
        mismatch  = (paddr != cap_addr) || (pwrite != cap_write) ||
                    (cap_write && (pwdata != cap_wdata));
        set_bits  = '0;

        if (in_access) begin
            if (mismatch) begin
                set_bits[ERR_UNSTABLE] = 1'b1;
            end
            if (!psel) begin
                set_bits[ERR_PSEL_DROP] = 1'b1;
            end else if (!penable) begin
                set_bits[ERR_ORDER] = 1'b1;
            end else if (!pready && (wait_base == WAIT_LAST)) begin
                // Only the step that lands on TIMEOUT flags; the count keeps
                // rising (or saturates above it) so this fires once per transfer.
                set_bits[ERR_TIMEOUT] = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (penable) begin
                        set_bits[ERR_ORDER] = 1'b1;
                    end
                    if (done && !psel && pready) begin
                        set_bits[ERR_PREADY_HOLD] = 1'b1;
                    end
                end
                SETUP: begin
                    // Any SETUP-state sample that is not psel&penable means
                    // the ACCESS phase never arrived.
                    set_bits[ERR_NO_ACCESS] = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_write <= 1'b0;
            wait_cnt  <= '0;
            done      <= 1'b0;
            err_flags <= '0;
            xfer_cnt  <= '0;
        end else begin
            err_flags <= (err_flags & ~{ERR_N{err_clr}}) | set_bits;
            done      <= 1'b0;

            if (in_access) begin
                if (!psel || !penable) begin
                    state <= IDLE;
                end else if (pready) begin
                    state    <= IDLE;
                    xfer_cnt <= xfer_cnt + 1'b1;
                    done     <= 1'b1;
                end else begin
                    state    <= ACCESS;
                    wait_cnt <= wait_inc;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (psel && !penable) begin
                            state     <= SETUP;
                            cap_addr  <= paddr;
                            cap_write <= pwrite;
                            cap_wdata <= pwdata;
                        end
                    end
                    SETUP: begin
                        if (!psel) begin
                            state <= IDLE;
                        end else begin
                            // Repeated SETUP: track the newest address phase.
                            cap_addr  <= paddr;
                            cap_write <= pwrite;
                            cap_wdata <= pwdata;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/apb_protocol_checker.sv
// rtl/apb_protocol_checker.sv - passive multi-channel APB protocol checker
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   psel         [NUM_CH]          per-channel select
//   penable      [NUM_CH]          per-channel enable
//   pwrite       [NUM_CH]          per-channel direction
//   paddr        [NUM_CH*ADDR_W]   channel i at [i*ADDR_W +: ADDR_W]
//   pwdata       [NUM_CH*DATA_W]   channel i at [i*DATA_W +: DATA_W]
//   pready       [NUM_CH]          per-channel ready
//   err_clr      [NUM_CH]          per-channel sticky-flag clear
//   err_flags    [NUM_CH*6]        channel i at [i*6 +: 6]
//   err_irq                        registered OR of every err_flags bit
//   xfer_cnt     [NUM_CH*CNT_W]    completed transfers, channel i at [i*CNT_W +: CNT_W]
module apb_protocol_checker
    import apb_chk_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         psel,
    input  logic [NUM_CH-1:0]         penable,
    input  logic [NUM_CH-1:0]         pwrite,
    input  logic [NUM_CH*ADDR_W-1:0]  paddr,
    input  logic [NUM_CH*DATA_W-1:0]  pwdata,
    input  logic [NUM_CH-1:0]         pready,
    input  logic [NUM_CH-1:0]         err_clr,
    output logic [NUM_CH*ERR_N-1:0]   err_flags,
    output logic                      err_irq,
    output logic [NUM_CH*CNT_W-1:0]   xfer_cnt
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        apb_chk_ch #(
            .ADDR_W  (ADDR_W),
            .DATA_W  (DATA_W),
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .psel      (psel[i]),
            .penable   (penable[i]),
            .pwrite    (pwrite[i]),
            .paddr     (paddr[i*ADDR_W +: ADDR_W]),
            .pwdata    (pwdata[i*DATA_W +: DATA_W]),
            .pready    (pready[i]),
            .err_clr   (err_clr[i]),
            .err_flags (err_flags[i*ERR_N +: ERR_N]),
            .xfer_cnt  (xfer_cnt[i*CNT_W +: CNT_W])
        );
    end

    // Built from the registered flags, so the interrupt trails them by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_irq <= 1'b0;
        end else begin
            err_irq <= |err_flags;
        end
    end

endmodule

// File: tb/tb_apb_protocol_checker.sv
// tb/tb_apb_protocol_checker.sv - scoreboard bench for apb_protocol_checker
module tb_apb_protocol_checker;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 16;
    localparam int CW  = 16;
    localparam int EW  = 6;

    logic                clk     = 1'b0;
    logic                rst_n   = 1'b0;
    logic [NCH-1:0]      psel    = '0;
    logic [NCH-1:0]      penable = '0;
    logic [NCH-1:0]      pwrite  = '0;
    logic [NCH-1:0]      pready  = '0;
    logic [NCH-1:0]      err_clr = '0;
    logic [NCH*AW-1:0]   paddr   = '0;
    logic [NCH*DW-1:0]   pwdata  = '0;
    logic [NCH*EW-1:0]   err_flags;
    logic                err_irq;
    logic [NCH*CW-1:0]   xfer_cnt;

    apb_protocol_checker #(
        .NUM_CH (NCH), .ADDR_W (AW), .DATA_W (DW), .TIMEOUT (TO), .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .err_clr   (err_clr),
        .err_flags (err_flags),
        .err_irq   (err_irq),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH*EW-1:0] flags;
        logic              irq;
        logic [NCH*CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Stimulus for the next cycle.
    bit            d_rst;
    bit            d_psel[NCH], d_pen[NCH], d_wr[NCH], d_rdy[NCH], d_clr[NCH];
    logic [AW-1:0] d_addr[NCH];
    logic [DW-1:0] d_wd[NCH];

    // Reference model: per channel, where the transfer stands (0 idle,
    // 1 address phase seen, 2 waiting in access), what was promised in the
    // address phase, and the observable results.
    int            m_ph[NCH];
    logic [AW-1:0] m_addr[NCH];
    logic [DW-1:0] m_wd[NCH];
    bit            m_wr[NCH];
    int            m_wait[NCH];
    bit            m_to[NCH];
    bit            m_done[NCH];
    bit [5:0]      m_fl[NCH];
    int            m_cnt[NCH];

    // Random master per channel.
    int            g_ph[NCH];
    bit            g_slow[NCH];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] fl(input int c);
        return 64'(err_flags[c*EW +: EW]);
    endfunction

    function automatic logic [63:0] cn(input int c);
        return 64'(xfer_cnt[c*CW +: CW]);
    endfunction

    function automatic void model_step();
        exp_t e;
        bit   any_flag;
        bit   acc;
        bit   was_done;
        bit [5:0] s;
        any_flag = 1'b0;
        for (int c = 0; c < NCH; c++) any_flag |= (m_fl[c] != 6'd0);
        for (int c = 0; c < NCH; c++) begin
            if (!d_rst) begin
                m_ph[c] = 0; m_wait[c] = 0; m_to[c] = 1'b0; m_done[c] = 1'b0;
                m_fl[c] = 6'd0; m_cnt[c] = 0;
                m_addr[c] = '0; m_wd[c] = '0; m_wr[c] = 1'b0;
            end else begin
                s = 6'd0;
                acc = (m_ph[c] == 2) || (m_ph[c] == 1 && d_psel[c] && d_pen[c]);
                if (m_ph[c] == 1 && acc) begin
                    m_wait[c] = 0;
                    m_to[c]   = 1'b0;
                end
                was_done  = m_done[c];
                m_done[c] = 1'b0;
                if (acc) begin
                    if (d_addr[c] != m_addr[c] || d_wr[c] != m_wr[c] ||
                        (m_wr[c] && d_wd[c] != m_wd[c])) s[2] = 1'b1;
                    if (!d_psel[c]) begin
                        s[4] = 1'b1; m_ph[c] = 0;
                    end else if (!d_pen[c]) begin
                        s[0] = 1'b1; m_ph[c] = 0;
                    end else if (d_rdy[c]) begin
                        m_cnt[c] = (m_cnt[c] + 1) % (1 << CW);
                        m_done[c] = 1'b1; m_ph[c] = 0;
                    end else begin
                        m_ph[c] = 2;
                        if (m_wait[c] < 65535) m_wait[c]++;
                        if (m_wait[c] == TO && !m_to[c]) begin
                            s[3] = 1'b1; m_to[c] = 1'b1;
                        end
                    end
                end else if (m_ph[c] == 1) begin
                    s[1] = 1'b1;
                    if (!d_psel[c]) m_ph[c] = 0;
                    else begin
                        m_addr[c] = d_addr[c]; m_wr[c] = d_wr[c]; m_wd[c] = d_wd[c];
                    end
                end else begin
                    if (d_pen[c]) s[0] = 1'b1;
                    if (was_done && !d_psel[c] && d_rdy[c]) s[5] = 1'b1;
                    if (d_psel[c] && !d_pen[c]) begin
                        m_ph[c] = 1;
                        m_addr[c] = d_addr[c]; m_wr[c] = d_wr[c]; m_wd[c] = d_wd[c];
                    end
                end
                m_fl[c] = (d_clr[c] ? 6'd0 : m_fl[c]) | s;
            end
            e.flags[c*EW +: EW] = m_fl[c];
            e.cnt[c*CW +: CW]   = CW'(m_cnt[c]);
        end
        e.irq = d_rst ? any_flag : 1'b0;
        sb_q.push_back(e);
    endfunction

    task automatic cyc();
        @(negedge clk);
        rst_n = d_rst;
        for (int c = 0; c < NCH; c++) begin
            psel[c]    = d_psel[c];
            penable[c] = d_pen[c];
            pwrite[c]  = d_wr[c];
            pready[c]  = d_rdy[c];
            err_clr[c] = d_clr[c];
            paddr[c*AW +: AW]  = d_addr[c];
            pwdata[c*DW +: DW] = d_wd[c];
        end
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_all();
        for (int c = 0; c < NCH; c++) begin
            d_psel[c] = 1'b0; d_pen[c] = 1'b0; d_rdy[c] = 1'b0; d_clr[c] = 1'b0;
        end
    endtask

    task automatic gen_random();
        int r;
        for (int c = 0; c < NCH; c++) begin
            d_clr[c] = ($urandom_range(0, 19) == 0);
            case (g_ph[c])
                0: begin
                    r = $urandom_range(0, 15);
                    d_rdy[c] = ($urandom_range(0, 9) == 0);
                    if (r < 7) begin
                        d_psel[c] = 1'b1; d_pen[c] = 1'b0;
                        d_addr[c] = 32'($urandom_range(0, 7) * 4);
                        d_wr[c] = 1'($urandom_range(0, 1));
                        d_wd[c] = $urandom;
                        g_ph[c] = 1;
                    end else if (r == 7) begin
                        d_psel[c] = 1'($urandom_range(0, 1)); d_pen[c] = 1'b1;
                    end else begin
                        d_psel[c] = 1'b0; d_pen[c] = 1'b0;
                    end
                end
                1: begin
                    r = $urandom_range(0, 15);
                    if (r == 0) begin
                        d_psel[c] = 1'b0; g_ph[c] = 0;
                    end else if (r == 1) begin
                        d_addr[c] = d_addr[c] ^ 32'h8;
                    end else begin
                        d_pen[c] = 1'b1; g_ph[c] = 2;
                        g_slow[c] = ($urandom_range(0, 5) == 0);
                        d_rdy[c] = ($urandom_range(0, 2) == 0);
                        if (d_rdy[c]) g_ph[c] = 0;
                    end
                end
                default: begin
                    r = $urandom_range(0, 31);
                    d_rdy[c] = g_slow[c] ? ($urandom_range(0, 23) == 0)
                                         : ($urandom_range(0, 2) == 0);
                    if (r == 0) begin
                        d_psel[c] = 1'b0; d_pen[c] = 1'b0; g_ph[c] = 0;
                    end else if (r == 1) begin
                        d_pen[c] = 1'b0; g_ph[c] = 0;
                    end else if (r == 2) begin
                        d_addr[c] = d_addr[c] ^ 32'h4;
                    end else if (r == 3) begin
                        d_wd[c] = $urandom;
                    end
                    if (d_psel[c] && d_pen[c] && d_rdy[c]) g_ph[c] = 0;
                end
            endcase
        end
    endtask

    // Monitor: outputs update every cycle, so every pushed expectation is
    // compared one step after its clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_flags", 64'(err_flags), 64'(e.flags));
                chk("sb_irq",   64'(err_irq),   64'(e.irq));
                chk("sb_cnt",   64'(xfer_cnt),  64'(e.cnt));
            end
        end
    end

    initial begin
        d_rst = 1'b0;
        idle_all();
        for (int c = 0; c < NCH; c++) begin
            d_addr[c] = '0; d_wd[c] = '0; d_wr[c] = 1'b0; g_ph[c] = 0; g_slow[c] = 1'b0;
        end
        cyc(); cyc();
        chk("reset_flags", 64'(err_flags), 64'h0);
        chk("reset_irq",   64'(err_irq),   64'h0);
        chk("reset_cnt",   64'(xfer_cnt),  64'h0);
        d_rst = 1'b1;
        cyc();

        // Legal write on ch0 with two wait states.
        d_psel[0] = 1'b1; d_pen[0] = 1'b0; d_addr[0] = 32'h10; d_wr[0] = 1'b1; d_wd[0] = 32'hA5A5;
        cyc();
        d_pen[0] = 1'b1; d_rdy[0] = 1'b0; cyc(); cyc();
        d_rdy[0] = 1'b1; cyc();
        chk("s1_cnt0", cn(0), 64'h1);
        chk("s1_flags", 64'(err_flags), 64'h0);
        idle_all(); cyc();
        chk("s1_irq", 64'(err_irq), 64'h0);

        // Back-to-back reads on ch1.
        d_psel[1] = 1'b1; d_pen[1] = 1'b0; d_wr[1] = 1'b0; d_addr[1] = 32'h100; cyc();
        d_pen[1] = 1'b1; d_rdy[1] = 1'b1; d_wd[1] = $urandom; cyc();
        d_pen[1] = 1'b0; d_rdy[1] = 1'b0; d_addr[1] = 32'h104; cyc();
        d_pen[1] = 1'b1; d_rdy[1] = 1'b1; d_wd[1] = $urandom; cyc();
        idle_all(); cyc();
        chk("s2_cnt1", cn(1), 64'h2);
        chk("s2_flags1", fl(1), 64'h0);

        // pready left high after a completion on ch1.
        d_psel[1] = 1'b1; d_pen[1] = 1'b0; cyc();
        d_pen[1] = 1'b1; d_rdy[1] = 1'b1; cyc();
        d_psel[1] = 1'b0; d_pen[1] = 1'b0; d_rdy[1] = 1'b1; cyc();
        chk("s2b_hold", fl(1), 64'h20);
        d_rdy[1] = 1'b0; d_clr[1] = 1'b1; cyc();
        chk("s2b_clr", fl(1), 64'h0);
        idle_all(); cyc();

        // ch2 address moves in the second ACCESS cycle.
        d_psel[2] = 1'b1; d_pen[2] = 1'b0; d_addr[2] = 32'h20; d_wr[2] = 1'b1; d_wd[2] = 32'h55; cyc();
        d_pen[2] = 1'b1; d_rdy[2] = 1'b0; cyc();
        d_addr[2] = 32'h24; cyc();
        chk("s3_unstable", fl(2), 64'h4);
        chk("s3_irq_lag", 64'(err_irq), 64'h0);
        d_addr[2] = 32'h20; d_rdy[2] = 1'b1; cyc();
        chk("s3_irq", 64'(err_irq), 64'h1);
        chk("s3_other0", fl(0), 64'h0);
        chk("s3_other1", fl(1), 64'h0);
        chk("s3_other3", fl(3), 64'h0);
        idle_all(); d_clr[2] = 1'b1; cyc();
        idle_all(); cyc();

        // ch3 wait-state timeout.
        d_psel[3] = 1'b1; d_pen[3] = 1'b0; d_addr[3] = 32'h30; d_wr[3] = 1'b0; cyc();
        d_pen[3] = 1'b1; d_rdy[3] = 1'b0;
        for (int i = 0; i < TO - 1; i++) cyc();
        chk("s4_before", fl(3), 64'h0);
        cyc();
        chk("s4_timeout", fl(3), 64'h8);
        d_clr[3] = 1'b1; cyc();
        d_clr[3] = 1'b0;
        chk("s4_cleared", fl(3), 64'h0);
        cyc();
        chk("s4_once", fl(3), 64'h0);
        d_rdy[3] = 1'b1; cyc();
        chk("s4_cnt3", cn(3), 64'h1);
        idle_all(); cyc();

        // ch0 ORDER, then a clear coinciding with PSEL_DROP.
        d_pen[0] = 1'b1; cyc();
        chk("s5_order", fl(0), 64'h1);
        d_psel[0] = 1'b1; d_pen[0] = 1'b0; d_addr[0] = 32'h40; cyc();
        d_pen[0] = 1'b1; d_rdy[0] = 1'b0; cyc();
        d_psel[0] = 1'b0; d_pen[0] = 1'b0; d_clr[0] = 1'b1; cyc();
        chk("s5_clr_drop", fl(0), 64'h10);
        idle_all(); cyc();

        // Randomised traffic on all channels.
        for (int n = 0; n < 600; n++) begin
            gen_random();
            cyc();
        end

        // Park every channel mid-ACCESS, then reset asynchronously.
        idle_all(); cyc(); cyc();
        for (int c = 0; c < NCH; c++) begin
            d_psel[c] = 1'b1; d_pen[c] = 1'b0; d_addr[c] = 32'h50; d_wr[c] = 1'b0;
        end
        cyc();
        for (int c = 0; c < NCH; c++) d_pen[c] = 1'b1;
        cyc();
        #1;
        rst_n = 1'b0;
        d_rst = 1'b0;
        #1;
        chk("async_flags", 64'(err_flags), 64'h0);
        chk("async_irq",   64'(err_irq),   64'h0);
        chk("async_cnt",   64'(xfer_cnt),  64'h0);
        idle_all(); cyc(); cyc();
        d_rst = 1'b1; cyc();

        d_psel[2] = 1'b1; d_pen[2] = 1'b0; d_addr[2] = 32'h60; d_wr[2] = 1'b1; d_wd[2] = 32'h1234; cyc();
        d_pen[2] = 1'b1; d_rdy[2] = 1'b1; cyc();
        idle_all(); cyc();
        chk("post_rst_cnt2", cn(2), 64'h1);
        chk("post_rst_cnt0", cn(0), 64'h0);
        chk("post_rst_flags", 64'(err_flags), 64'h0);
        chk("sb_drain", 64'(sb_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
